// File: rtl/dual_lane_accum_pkg.sv
// Shared definitions for the two-lane PE-output accumulator: the batch state
// encoding, the lane count and the saturation bounds of a signed accumulator.
package ftdnn_acc_pkg;

  // S_FIRST: the next accepted beat opens a batch. S_ACC: a batch is open.
  typedef enum logic [0:0] {
    S_FIRST = 1'b0,
    S_ACC   = 1'b1
  } acc_state_e;

  // Lane 0 always occupies the low slice of every packed bus.
  localparam int N_LANE = 2;

  // Default accumulator width. Instances with another width derive their
  // bounds through the helper functions below.
  localparam int WID_ACC_DEF = 32;

  // Largest value representable in a signed field of 'wid' bits.
  function automatic logic signed [63:0] sat_hi(input int wid);
    return (64'sd1 <<< (wid - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of 'wid' bits.
  function automatic logic signed [63:0] sat_lo(input int wid);
    return -(64'sd1 <<< (wid - 1));
  endfunction

  // Bounds for the default width, one bit wider than the accumulator so they
  // can be compared directly against the guard-bit sum.
  localparam logic signed [WID_ACC_DEF:0] SAT_HI_DEF = (WID_ACC_DEF + 1)'(sat_hi(WID_ACC_DEF));
  localparam logic signed [WID_ACC_DEF:0] SAT_LO_DEF = (WID_ACC_DEF + 1)'(sat_lo(WID_ACC_DEF));

endpackage : ftdnn_acc_pkg

// File: rtl/dual_lane_accum_if.sv
// Beat-in / sum-out handshake bundle of the two-lane accumulator. The master
// side is the producer of products and consumer of sums; the slave side is
// the accumulator itself.
interface dual_lane_accum_if
  import ftdnn_acc_pkg::*;
#(
  parameter int WID_PROD = 16,
  parameter int WID_ACC  = 32
);

  // Input beat stream: {lane1, lane0} signed products.
  logic                       in_valid;
  logic                       in_ready;
  logic [N_LANE*WID_PROD-1:0] in_data;

  // Output sum register: {lane1, lane0} saturated sums plus per-lane flags.
  logic                       out_valid;
  logic                       out_ready;
  logic [N_LANE*WID_ACC-1:0]  out_data;
  logic [N_LANE-1:0]          out_ovf;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf,
    input  out_ready
  );

endinterface : dual_lane_accum_if

// File: rtl/dual_lane_accum_lane.sv
// One lane of the accumulator datapath: either loads the sign-extended
// product (first beat of a batch) or adds it to the running sum with
// saturation. Purely combinational; the parent owns all state.
module acc_sat_lane
  import ftdnn_acc_pkg::*;
#(
  parameter int WID_ACC = 32
) (
  input  logic [WID_ACC-1:0] i_acc,
  input  logic [WID_ACC-1:0] i_prod,
  input  logic               i_load_first,
  output logic [WID_ACC-1:0] o_acc_next,
  output logic               o_clamp
);

  // Bounds carried with one guard bit so the comparison against the
  // widened sum cannot itself wrap.
  localparam logic signed [WID_ACC:0] SAT_HI = (WID_ACC + 1)'(sat_hi(WID_ACC));
  localparam logic signed [WID_ACC:0] SAT_LO = (WID_ACC + 1)'(sat_lo(WID_ACC));

  // Two WID_ACC-bit signed operands never overflow WID_ACC+1 bits.
  logic signed [WID_ACC:0] w_sum;

  assign w_sum = {i_acc[WID_ACC-1], i_acc} + {i_prod[WID_ACC-1], i_prod};

  // Select load or saturating add, flagging any clamp.
  always_comb begin
    o_acc_next = i_prod;
    o_clamp    = 1'b0;
    if (!i_load_first) begin
      if (w_sum > SAT_HI) begin
        o_acc_next = SAT_HI[WID_ACC-1:0];
        o_clamp    = 1'b1;
      end else if (w_sum < SAT_LO) begin
        o_acc_next = SAT_LO[WID_ACC-1:0];
        o_clamp    = 1'b1;
      end else begin
        o_acc_next = w_sum[WID_ACC-1:0];
      end
    end
  end

endmodule : acc_sat_lane

// File: rtl/dual_lane_accum.sv
// Two-lane signed batch accumulator feeding the requantiser. Sums cfg_len
// beats per lane with saturation and hands each packed result to a one-deep
// valid/ready output register. The accumulator keeps running while a result
// waits; only a batch-closing beat can be held off by a full output register.
module dual_lane_accum
  import ftdnn_acc_pkg::*;
#(
  parameter int WID_PROD = 16,
  parameter int WID_ACC  = 32,
  parameter int WID_CNT  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WID_CNT-1:0] cfg_len,
  dual_lane_accum_if.slave   bus,
  output logic               busy
);

  // Batch state.
  acc_state_e                     r_state;
  logic [WID_CNT-1:0]             r_len;
  logic [WID_CNT-1:0]             r_cnt;
  logic [N_LANE-1:0][WID_ACC-1:0] r_acc;
  logic [N_LANE-1:0]              r_ovf;

  // Output register.
  logic                           r_out_valid;
  logic [N_LANE*WID_ACC-1:0]      r_out_data;
  logic [N_LANE-1:0]              r_out_ovf;

  // Beat decode.
  logic                           w_first;
  logic                           w_last;
  logic                           w_fire;
  logic                           w_in_ready;
  logic [WID_CNT-1:0]             w_len_eff;
  logic [WID_CNT:0]               w_cnt_inc;

  // Per-lane datapath.
  logic [N_LANE-1:0][WID_ACC-1:0] w_prod_sext;
  logic [N_LANE-1:0][WID_ACC-1:0] w_acc_next;
  logic [N_LANE-1:0]              w_clamp;
  logic [N_LANE-1:0]              w_ovf_next;

  // A first beat takes its length from cfg_len (zero meaning one); later beats
  // use the length latched when the batch opened.
  assign w_first   = (r_state == S_FIRST);
  assign w_len_eff = w_first ? ((cfg_len == '0) ? WID_CNT'(1) : cfg_len) : r_len;

  // Counter compare done one bit wider so a full-scale length cannot wrap.
  assign w_cnt_inc = {1'b0, r_cnt} + (WID_CNT + 1)'(1);
  assign w_last    = (w_cnt_inc == {1'b0, w_len_eff});

  // Only a closing beat can stall, and only while the held result is not
  // being taken this cycle; out_ready therefore reaches in_ready directly.
  assign w_in_ready = ~(w_last & r_out_valid & ~bus.out_ready);
  assign w_fire     = bus.in_valid & w_in_ready;

  for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
    logic [WID_PROD-1:0] w_prod;

    assign w_prod          = bus.in_data[gi*WID_PROD +: WID_PROD];
    assign w_prod_sext[gi] = {{(WID_ACC - WID_PROD){w_prod[WID_PROD-1]}}, w_prod};

    acc_sat_lane #(
      .WID_ACC (WID_ACC)
    ) u_lane (
      .i_acc        (r_acc[gi]),
      .i_prod       (w_prod_sext[gi]),
      .i_load_first (w_first),
      .o_acc_next   (w_acc_next[gi]),
      .o_clamp      (w_clamp[gi])
    );

    // Sticky flag restarts with each batch and latches any clamp after that.
    assign w_ovf_next[gi] = (r_ovf[gi] & ~w_first) | w_clamp[gi];
  end

  // Batch FSM, accumulators and output register in one clocked process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FIRST;
      r_len       <= WID_CNT'(1);
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= '0;
    end else begin
      if (w_fire) begin
        r_acc <= w_acc_next;
        r_ovf <= w_ovf_next;
        if (w_first) begin
          r_len <= w_len_eff;
        end
        if (w_last) begin
          r_state <= S_FIRST;
          r_cnt   <= '0;
        end else begin
          r_state <= S_ACC;
          r_cnt   <= w_cnt_inc[WID_CNT-1:0];
        end
      end

      // A closing beat always wins over a drain so a result replaced in the
      // same cycle it is consumed never produces a bubble.
      if (w_fire && w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_next;
        r_out_ovf   <= w_ovf_next;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign busy          = (r_state == S_ACC);

endmodule : dual_lane_accum

// File: tb/tb_dual_lane_accum.sv
// Directed bench for dual_lane_accum: a 32-bit instance carries most checks,
// a 20-bit instance sharing the same input stimulus covers saturation.
`timescale 1ns/1ps
module tb_dual_lane_accum;
  import ftdnn_acc_pkg::*;

  localparam int WP   = 16;
  localparam int WA   = 32;
  localparam int WA20 = 20;
  localparam int WC   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WC-1:0] cfg_len = 8'd1;
  logic          busy;
  logic          busy20;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] xfer_q[$];

  dual_lane_accum_if #(.WID_PROD(WP), .WID_ACC(WA))   bus ();
  dual_lane_accum_if #(.WID_PROD(WP), .WID_ACC(WA20)) bus20 ();

  assign bus20.in_valid  = bus.in_valid;
  assign bus20.in_data   = bus.in_data;
  assign bus20.out_ready = bus.out_ready;

  dual_lane_accum #(.WID_PROD(WP), .WID_ACC(WA), .WID_CNT(WC)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_len (cfg_len),
    .bus     (bus),
    .busy    (busy)
  );

  dual_lane_accum #(.WID_PROD(WP), .WID_ACC(WA20), .WID_CNT(WC)) u_dut20 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_len (cfg_len),
    .bus     (bus20),
    .busy    (busy20)
  );

  always #5 clk = ~clk;

  // Log every output transfer of the 32-bit instance (sampled mid-cycle).
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      xfer_q.push_back(bus.out_data);
      $display("xfer %0d: out_data=%h out_ovf=%b", xfer_q.size(), bus.out_data, bus.out_ovf);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [15:0] l0, input logic [15:0] l1);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {l1, l0};
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("beat_accept", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst20_out_valid", 64'(bus20.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [7:0]        len;
    int                nb;
    logic [3:0][15:0]  l0;
    logic [3:0][15:0]  l1;
    logic [31:0]       e0;
    logic [31:0]       e1;
    logic [1:0]        eovf;
  } batch_t;

  typedef struct {
    logic [15:0] l0;
    logic [15:0] l1;
    logic [63:0] e;
  } single_t;

  batch_t  bt[4];
  single_t sv[8];

  initial begin
    // Multi-beat batches, out_ready held high.
    bt[0].len = 8'd4; bt[0].nb = 4;
    bt[0].l0 = {16'h0007, 16'hFFCE, 16'h00C8, 16'h0064};
    bt[0].l1 = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    bt[0].e0 = 32'h0000_0101; bt[0].e1 = 32'hFFFF_FFFC; bt[0].eovf = 2'b00;
    bt[1].len = 8'd3; bt[1].nb = 3;
    bt[1].l0 = {16'h0000, 16'h8000, 16'h8000, 16'h8000};
    bt[1].l1 = {16'h0000, 16'hFFFE, 16'h0001, 16'h7FFF};
    bt[1].e0 = 32'hFFFE_8000; bt[1].e1 = 32'h0000_7FFE; bt[1].eovf = 2'b00;
    bt[2].len = 8'd2; bt[2].nb = 2;
    bt[2].l0 = {16'h0000, 16'h0000, 16'hFFFB, 16'h0005};
    bt[2].l1 = {16'h0000, 16'h0000, 16'h0001, 16'h1234};
    bt[2].e0 = 32'h0000_0000; bt[2].e1 = 32'h0000_1235; bt[2].eovf = 2'b00;
    bt[3].len = 8'd0; bt[3].nb = 1;
    bt[3].l0 = {16'h0000, 16'h0000, 16'h0000, 16'hFFF9};
    bt[3].l1 = {16'h0000, 16'h0000, 16'h0000, 16'h002A};
    bt[3].e0 = 32'hFFFF_FFF9; bt[3].e1 = 32'h0000_002A; bt[3].eovf = 2'b00;

    // Single-beat stream: each result is the sign-extended beat.
    sv[0] = '{16'h8000, 16'h7FFF, {32'h0000_7FFF, 32'hFFFF_8000}};
    sv[1] = '{16'h0001, 16'hFFFF, {32'hFFFF_FFFF, 32'h0000_0001}};
    sv[2] = '{16'h7FFF, 16'h8000, {32'hFFFF_8000, 32'h0000_7FFF}};
    sv[3] = '{16'hFFFF, 16'h0000, {32'h0000_0000, 32'hFFFF_FFFF}};
    sv[4] = '{16'h1234, 16'hABCD, {32'hFFFF_ABCD, 32'h0000_1234}};
    sv[5] = '{16'h0000, 16'h0001, {32'h0000_0001, 32'h0000_0000}};
    sv[6] = '{16'hC000, 16'h4000, {32'h0000_4000, 32'hFFFF_C000}};
    sv[7] = '{16'h00FF, 16'hFF00, {32'hFFFF_FF00, 32'h0000_00FF}};

    do_reset();

    // Table-driven batches; cfg_len is scrambled mid-batch and must be ignored.
    bus.out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cfg_len = bt[b].len;
      for (int j = 0; j < bt[b].nb; j++) begin
        send_beat(bt[b].l0[j], bt[b].l1[j]);
        if (j == 0) cfg_len = 8'd9;
        if (j < bt[b].nb - 1) begin
          chk("batch_busy", 64'(busy), 64'd1);
          chk("batch_no_early_valid", 64'(bus.out_valid), 64'd0);
        end
      end
      bus.in_valid = 1'b0;
      chk("batch_valid", 64'(bus.out_valid), 64'd1);
      chk("batch_lane0", 64'(bus.out_data[31:0]), 64'(bt[b].e0));
      chk("batch_lane1", 64'(bus.out_data[63:32]), 64'(bt[b].e1));
      chk("batch_ovf", 64'(bus.out_ovf), 64'(bt[b].eovf));
      chk("batch_idle", 64'(busy), 64'd0);
      tick();
      chk("batch_pulse_end", 64'(bus.out_valid), 64'd0);
    end

    // Saturation on the 20-bit instance, then a clean batch clears the flag.
    do_reset();
    bus.out_ready = 1'b1;
    cfg_len = 8'd20;
    for (int j = 0; j < 20; j++) send_beat(16'h7FFF, 16'h0000);
    bus.in_valid = 1'b0;
    chk("sat20_valid", 64'(bus20.out_valid), 64'd1);
    chk("sat20_lane0", 64'(bus20.out_data[19:0]), 64'h7FFFF);
    chk("sat20_lane1", 64'(bus20.out_data[39:20]), 64'h0);
    chk("sat20_ovf", 64'(bus20.out_ovf), 64'd1);
    chk("sat20_in_ready", 64'(bus20.in_ready), 64'd1);
    chk("sat32_lane0", 64'(bus.out_data[31:0]), 64'h0009_FFEC);
    chk("sat32_ovf", 64'(bus.out_ovf), 64'd0);
    tick();
    for (int j = 0; j < 20; j++) send_beat(16'h0001, 16'h0000);
    bus.in_valid = 1'b0;
    chk("sat20_next_lane0", 64'(bus20.out_data[19:0]), 64'd20);
    chk("sat20_next_ovf", 64'(bus20.out_ovf), 64'd0);
    chk("sat20_busy", 64'(busy20), 64'd0);
    tick();

    // Length 0 then 1: one result per cycle.
    for (int i = 0; i < 8; i++) begin
      cfg_len = (i < 4) ? 8'd0 : 8'd1;
      bus.in_valid = 1'b1;
      bus.in_data  = {sv[i].l1, sv[i].l0};
      tick();
      chk("len1_valid", 64'(bus.out_valid), 64'd1);
      chk("len1_data", bus.out_data, sv[i].e);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("len1_drained", 64'(bus.out_valid), 64'd0);

    // Back-pressure: len 2, four beats, output not taken.
    xfer_q.delete();
    cfg_len = 8'd2;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = {16'd1, 16'd10};
    #1 chk("stall_b1_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_data = {16'd2, 16'd20};
    #1 chk("stall_b2_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("stall_r1_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_r1_data", bus.out_data, {32'd3, 32'd30});
    bus.in_data = {16'd5, 16'd5};
    #1 chk("stall_b3_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_data = {16'd6, 16'd6};
    #1 chk("stall_b4_blocked", 64'(bus.in_ready), 64'd0);
    tick();
    chk("stall_hold_data", bus.out_data, {32'd3, 32'd30});
    #1 chk("stall_b4_blocked2", 64'(bus.in_ready), 64'd0);
    tick();
    chk("stall_hold_data2", bus.out_data, {32'd3, 32'd30});
    bus.out_ready = 1'b1;
    #1 chk("stall_release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("stall_r2_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_r2_data", bus.out_data, {32'd11, 32'd11});
    chk("stall_r2_busy", 64'(busy), 64'd0);
    tick();
    chk("stall_r2_held", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("stall_drained", 64'(bus.out_valid), 64'd0);
    chk("stall_xfer_count", 64'(xfer_q.size()), 64'd2);
    if (xfer_q.size() == 2) begin
      chk("stall_xfer0", xfer_q[0], {32'd3, 32'd30});
      chk("stall_xfer1", xfer_q[1], {32'd11, 32'd11});
    end

    // Last beat arrives in the same cycle the held result is taken.
    xfer_q.delete();
    cfg_len = 8'd1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = {16'h0022, 16'h0011};
    tick();
    bus.in_valid = 1'b0;
    chk("swap_a_data", bus.out_data, {32'h22, 32'h11});
    tick();
    bus.in_valid = 1'b1;
    bus.in_data = {16'h0044, 16'h0033};
    bus.out_ready = 1'b1;
    #1 chk("swap_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("swap_valid", 64'(bus.out_valid), 64'd1);
    chk("swap_b_data", bus.out_data, {32'h44, 32'h33});
    tick();
    bus.out_ready = 1'b1;
    tick();
    chk("swap_drained", 64'(bus.out_valid), 64'd0);
    chk("swap_xfer_count", 64'(xfer_q.size()), 64'd2);
    if (xfer_q.size() == 2) begin
      chk("swap_xfer0", xfer_q[0], {32'h22, 32'h11});
      chk("swap_xfer1", xfer_q[1], {32'h44, 32'h33});
    end

    // Asynchronous reset in the middle of a batch with a result held.
    cfg_len = 8'd1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = {16'h0000, 16'h0055};
    tick();
    cfg_len = 8'd4;
    send_beat(16'h0001, 16'h0000);
    send_beat(16'h0001, 16'h0000);
    bus.in_valid = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_held_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", bus.out_data, 64'd0);
    chk("mid_rst_ovf", 64'(bus.out_ovf), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) send_beat(16'h0001, 16'h0000);
    bus.in_valid = 1'b0;
    chk("mid_fresh_valid", 64'(bus.out_valid), 64'd1);
    chk("mid_fresh_data", bus.out_data, {32'd0, 32'd4});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dual_lane_accum
